// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: reset vector, mapped instruction windows,
// FSM encodings and the legal-PC predicate used by the fetch unit and memory models.
package fetch_pkg;
    localparam logic [31:0] RESET_VECTOR = 32'h9fc0_0000;
    localparam int          BUF_DEPTH    = 2;

    localparam logic [31:0] BOOT_BASE  = 32'h9fc0_0000;
    localparam logic [31:0] BOOT_LIMIT = 32'h9fc0_0400;
    localparam logic [31:0] TEXT_BASE  = 32'h0040_0000;
    localparam logic [31:0] TEXT_LIMIT = 32'h0040_0400;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    function automatic logic pc_legal(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) &&
               (((pc >= BOOT_BASE) && (pc < BOOT_LIMIT)) ||
                ((pc >= TEXT_BASE) && (pc < TEXT_LIMIT)));
    endfunction
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} between fetch and decode. Pointer-based so the
// head entry never moves while it waits for decode.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_instr,
    input  logic        pop,
    input  logic        flush,
    output logic [1:0]  count,
    output logic        head_valid,
    output logic [31:0] head_pc,
    output logic [31:0] head_instr
);
    logic [31:0] pc_q    [2];
    logic [31:0] instr_q [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic        do_pop;
    logic        do_push;

    assign do_pop     = pop && (count != 2'd0);
    assign do_push    = push && ((count != 2'(BUF_DEPTH)) || do_pop);
    assign head_valid = (count != 2'd0);
    assign head_pc    = pc_q[rd_ptr];
    assign head_instr = instr_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                pc_q[wr_ptr]    <= push_pc;
                instr_q[wr_ptr] <= push_instr;
                wr_ptr          <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch initiator: owns the PC, captures ROM data into the fetch buffer, and
// halts in FAULT on an unmapped or misaligned PC until reset or redirect.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = fetch_pkg::RESET_VECTOR
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutInstruction,
    output logic [31:0] OutPC,
    output logic        Fault,
    output logic [31:0] FaultAddr
);
    fetch_state_t state;
    logic [31:0]  pc;
    logic [1:0]   count;
    logic         pc_ok;
    logic         pop;
    logic         cap;

    assign pc_ok   = pc_legal(pc);
    assign pop     = OutValid && OutReady;
    // A redirect wins over capture: the fetched word belongs to the squashed path.
    assign cap     = (state == FETCH) && pc_ok && !RedirectValid &&
                     ((count != 2'(BUF_DEPTH)) || pop);
    assign Address = (state == FAULT) ? FaultAddr : pc;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc        <= RESET_VECTOR;
            state     <= FETCH;
            Fault     <= 1'b0;
            FaultAddr <= 32'h0;
        end else if (RedirectValid) begin
            pc <= RedirectTarget;
            if (pc_legal(RedirectTarget)) begin
                state <= FETCH;
                Fault <= 1'b0;
            end else begin
                state     <= FAULT;
                Fault     <= 1'b1;
                FaultAddr <= RedirectTarget;
            end
        end else if (state == FETCH) begin
            if (!pc_ok) begin
                state     <= FAULT;
                Fault     <= 1'b1;
                FaultAddr <= pc;
            end else if (cap) begin
                pc <= pc + 32'd4;
            end
        end
    end

    fetch_buffer u_buf (
        .clk        (Clk),
        .reset      (Reset),
        .push       (cap),
        .push_pc    (pc),
        .push_instr (Instruction),
        .pop        (pop),
        .flush      (RedirectValid),
        .count      (count),
        .head_valid (OutValid),
        .head_pc    (OutPC),
        .head_instr (OutInstruction)
    );
endmodule
